// File: rtl/hex_loader.sv
// Intel-HEX ASCII stream decoder that writes each 4-byte data record as one
// 32-bit word onto a generic bus master port; stops on EOF or the first error.
module hex_loader #(
    parameter string       BUS_ENDIANNESS  = "little",
    parameter int unsigned WORD_ADDR_SHIFT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] addr,
    output logic        ren,
    output logic        wen,
    output logic [31:0] wdata,
    output logic [3:0]  byte_en,
    input  logic [31:0] rdata,
    input  logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [15:0] rec_count
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam bit          BIG_ENDIAN = (BUS_ENDIANNESS == "big");

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_ADDR, S_TYPE, S_DATA, S_CSUM, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t        state, state_next;
    logic [2:0]    digit_cnt;
    logic [3:0]    hi_nib;
    logic [7:0]    sum;
    logic [7:0]    rec_len;
    logic [7:0]    rec_type;
    logic [15:0]   rec_addr;
    logic [DW-1:0] rec_data;

    logic          accept_c;
    logic          is_hex_c;
    logic [3:0]    nib_c;
    logic [7:0]    byte_c;
    logic [1:0]    err_c;
    logic          in_ready_d;
    logic          wen_d;
    logic [DW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [3:0]    byte_en_d;
    logic [DW-1:0] bus_wdata_c;
    logic          unused_rdata;

    assign unused_rdata = ^rdata;
    assign ren          = 1'b0;
    assign accept_c     = in_valid & in_ready;
    assign byte_c       = {hi_nib, nib_c};
    assign bus_wdata_c  = BIG_ENDIAN ? {rec_data[7:0], rec_data[15:8], rec_data[23:16], rec_data[31:24]}
                                     : rec_data;

    // ASCII hex digit decode
    always_comb begin
        is_hex_c = 1'b1;
        nib_c    = 4'h0;
        if (in_data >= 8'h30 && in_data <= 8'h39)      nib_c = 4'(in_data - 8'h30);
        else if (in_data >= 8'h61 && in_data <= 8'h66) nib_c = 4'(in_data - 8'h57);
        else if (in_data >= 8'h41 && in_data <= 8'h46) nib_c = 4'(in_data - 8'h37);
        else                                           is_hex_c = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_c      = 2'd0;
        case (state)
            S_IDLE: if (accept_c) begin
                if (in_data == 8'h3A) state_next = S_LEN;
                else if (in_data != 8'h0D && in_data != 8'h0A && in_data != 8'h20) begin
                    state_next = S_ERR;
                    err_c      = 2'd1;
                end
            end
            S_LEN, S_ADDR, S_TYPE, S_DATA, S_CSUM: if (accept_c) begin
                if (!is_hex_c) begin
                    state_next = S_ERR;
                    err_c      = 2'd1;
                end else begin
                    case (state)
                        S_LEN:  if (digit_cnt == 3'd1) state_next = S_ADDR;
                        S_ADDR: if (digit_cnt == 3'd3) state_next = S_TYPE;
                        S_DATA: if (digit_cnt == 3'd7) state_next = S_CSUM;
                        S_TYPE: if (digit_cnt == 3'd1) begin
                            if (byte_c == 8'h00 && rec_len == 8'h04)      state_next = S_DATA;
                            else if (byte_c == 8'h01 && rec_len == 8'h00) state_next = S_CSUM;
                            else begin
                                state_next = S_ERR;
                                err_c      = 2'd3;
                            end
                        end
                        default: if (digit_cnt == 3'd1) begin
                            if (8'(sum + byte_c) == 8'h00)
                                state_next = (rec_type == 8'h00) ? S_WRITE : S_DONE;
                            else begin
                                state_next = S_ERR;
                                err_c      = 2'd2;
                            end
                        end
                    endcase
                end
            end
            S_WRITE: if (!busy) state_next = S_IDLE;
            default: state_next = state;
        endcase
    end

    // Bus outputs follow the next state so they are registered yet valid on WRITE entry
    always_comb begin
        in_ready_d = (state_next == S_IDLE) || (state_next == S_LEN)  || (state_next == S_ADDR) ||
                     (state_next == S_TYPE) || (state_next == S_DATA) || (state_next == S_CSUM);
        wen_d      = (state_next == S_WRITE);
        addr_d     = '0;
        wdata_d    = '0;
        byte_en_d  = 4'h0;
        if (wen_d) begin
            addr_d    = {16'h0, rec_addr} << WORD_ADDR_SHIFT;
            wdata_d   = bus_wdata_c;
            byte_en_d = 4'hF;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_ready  <= 1'b0;
            wen       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            byte_en   <= 4'h0;
            done      <= 1'b0;
            error     <= 2'd0;
            rec_count <= '0;
            digit_cnt <= 3'd0;
            hi_nib    <= 4'h0;
            sum       <= 8'h00;
            rec_len   <= 8'h00;
            rec_type  <= 8'h00;
            rec_addr  <= 16'h0;
            rec_data  <= '0;
        end else begin
            in_ready <= in_ready_d;
            wen      <= wen_d;
            addr     <= addr_d;
            wdata    <= wdata_d;
            byte_en  <= byte_en_d;
            if (err_c != 2'd0)         error <= err_c;
            if (state_next == S_DONE)  done  <= 1'b1;
            if (state == S_WRITE && !busy && rec_count != {CW{1'b1}})
                rec_count <= CW'(rec_count + 16'd1);
            if (accept_c) begin
                if (state == S_IDLE) begin
                    digit_cnt <= 3'd0;
                    sum       <= 8'h00;
                end else if (is_hex_c && state != S_WRITE && state != S_DONE && state != S_ERR) begin
                    digit_cnt <= (state_next != state) ? 3'd0 : 3'(digit_cnt + 3'd1);
                    if (!digit_cnt[0]) hi_nib <= nib_c;
                    else               sum    <= 8'(sum + byte_c);
                    if (state == S_LEN && digit_cnt[0])  rec_len  <= byte_c;
                    if (state == S_TYPE && digit_cnt[0]) rec_type <= byte_c;
                    if (state == S_ADDR) rec_addr <= {rec_addr[11:0], nib_c};
                    if (state == S_DATA) rec_data <= {rec_data[27:0], nib_c};
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_loader.sv
// Directed bench for hex_loader: little- and big-endian instances share one stimulus stream.
module tb_hex_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [31:0] rdata = 32'h0;
    logic        busy = 1'b0;

    logic        in_ready_le, ren_le, wen_le, done_le;
    logic [31:0] addr_le, wdata_le;
    logic [3:0]  byte_en_le;
    logic [1:0]  error_le;
    logic [15:0] rec_count_le;

    logic        in_ready_be, ren_be, wen_be, done_be;
    logic [31:0] addr_be, wdata_be;
    logic [3:0]  byte_en_be;
    logic [1:0]  error_be;
    logic [15:0] rec_count_be;

    int n_checks = 0;
    int n_pass   = 0;

    int          wen_total = 0;
    int          unstable_total = 0;
    int          rdy_in_wen_total = 0;
    logic        wen_prev = 1'b0;
    logic [31:0] last_addr = 32'h0, last_wdata = 32'h0, last_wdata_be = 32'h0;
    logic [3:0]  last_be = 4'h0;

    always #5 clk = ~clk;

    hex_loader #(.BUS_ENDIANNESS("little"), .WORD_ADDR_SHIFT(2)) u_le (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_le),
        .addr(addr_le), .ren(ren_le), .wen(wen_le), .wdata(wdata_le), .byte_en(byte_en_le),
        .rdata(rdata), .busy(busy), .done(done_le), .error(error_le), .rec_count(rec_count_le)
    );

    hex_loader #(.BUS_ENDIANNESS("big"), .WORD_ADDR_SHIFT(2)) u_be (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_be),
        .addr(addr_be), .ren(ren_be), .wen(wen_be), .wdata(wdata_be), .byte_en(byte_en_be),
        .rdata(rdata), .busy(busy), .done(done_be), .error(error_be), .rec_count(rec_count_be)
    );

    // Bus write monitor: counts wen cycles and flags output changes within one write
    always @(negedge clk) begin
        if (wen_le) begin
            wen_total = wen_total + 1;
            if (wen_prev && (addr_le != last_addr || wdata_le != last_wdata || byte_en_le != last_be
                             || wdata_be != last_wdata_be))
                unstable_total = unstable_total + 1;
            if (in_ready_le) rdy_in_wen_total = rdy_in_wen_total + 1;
            last_addr     = addr_le;
            last_wdata    = wdata_le;
            last_wdata_be = wdata_be;
            last_be       = byte_en_le;
        end
        wen_prev = wen_le;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input byte b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready_le && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_le) begin
            check("in_ready_timeout", 32'(in_ready_le), 32'd1);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    int w0, u0, r0, n;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready_le), 32'd0);
        check("rst_wen", 32'(wen_le), 32'd0);
        check("rst_done_err", {29'd0, done_le, error_le}, 32'd0);
        check("rst_rec_count", 32'(rec_count_le), 32'd0);
        check("rst_addr", addr_le, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready_le), 32'd1);

        // Basic data record, busy low
        w0 = wen_total;
        send_str(":0400400012345678A8\n");
        repeat (2) @(negedge clk);
        check("rec1_wen_cycles", 32'(wen_total - w0), 32'd1);
        check("rec1_addr", last_addr, 32'h0000_0100);
        check("rec1_wdata_le", last_wdata, 32'h1234_5678);
        check("rec1_wdata_be", last_wdata_be, 32'h7856_3412);
        check("rec1_byte_en", 32'(last_be), 32'hF);
        check("rec1_rec_count", 32'(rec_count_le), 32'd1);
        check("rec1_ren", 32'(ren_le), 32'd0);
        check("rec1_wen_low_after", 32'(wen_le), 32'd0);

        // Lowercase digits
        w0 = wen_total;
        send_str(":04004100deadbeef83\n");
        repeat (2) @(negedge clk);
        check("lc_wen_cycles", 32'(wen_total - w0), 32'd1);
        check("lc_addr", last_addr, 32'h0000_0104);
        check("lc_wdata", last_wdata, 32'hDEAD_BEEF);
        check("lc_rec_count", 32'(rec_count_le), 32'd2);

        // Write stretched by busy for three cycles
        w0 = wen_total; u0 = unstable_total; r0 = rdy_in_wen_total;
        busy = 1'b1;
        send_str(":0400400012345678A8");
        n = 0;
        @(negedge clk);
        while (!wen_le && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_wen_seen", 32'(wen_le), 32'd1);
        repeat (3) @(negedge clk);
        check("busy_count_held", 32'(rec_count_le), 32'd2);
        busy = 1'b0;
        send_byte(8'h0A);
        repeat (2) @(negedge clk);
        check("busy_wen_cycles", 32'(wen_total - w0), 32'd4);
        check("busy_stable", 32'(unstable_total - u0), 32'd0);
        check("busy_in_ready_low", 32'(rdy_in_wen_total - r0), 32'd0);
        check("busy_rec_count", 32'(rec_count_le), 32'd3);

        // Reset after six bytes of a record, then a clean load
        w0 = wen_total;
        send_str(":04004");
        do_reset();
        repeat (3) @(negedge clk);
        check("midrst_no_write", 32'(wen_total - w0), 32'd0);
        check("midrst_rec_count", 32'(rec_count_le), 32'd0);
        send_str(":0400400012345678A8\n");
        repeat (2) @(negedge clk);
        check("midrst_reload_wen", 32'(wen_total - w0), 32'd1);
        check("midrst_reload_wdata", last_wdata, 32'h1234_5678);
        check("midrst_reload_count", 32'(rec_count_le), 32'd1);

        // Checksum mismatch
        do_reset();
        w0 = wen_total;
        send_str(":0400400012345678A9");
        repeat (3) @(negedge clk);
        check("csum_error", 32'(error_le), 32'd2);
        check("csum_no_write", 32'(wen_total - w0), 32'd0);
        check("csum_in_ready", 32'(in_ready_le), 32'd0);

        // EOF record
        do_reset();
        send_str(":00000001FF");
        @(negedge clk);
        check("eof_done", 32'(done_le), 32'd1);
        check("eof_error", 32'(error_le), 32'd0);
        check("eof_in_ready", 32'(in_ready_le), 32'd0);

        // Unsupported length/type, error on second type digit
        do_reset();
        send_str(":02004000");
        @(negedge clk);
        check("unsup_error", 32'(error_le), 32'd3);
        check("unsup_in_ready", 32'(in_ready_le), 32'd0);

        // Bad character inside the data field
        do_reset();
        w0 = wen_total;
        send_str(":0400400012G");
        @(negedge clk);
        check("badchar_error", 32'(error_le), 32'd1);
        check("badchar_done", 32'(done_le), 32'd0);
        check("badchar_no_write", 32'(wen_total - w0), 32'd0);

        // Bad character while idle
        do_reset();
        send_str(" \r\nx");
        @(negedge clk);
        check("idle_badchar_error", 32'(error_le), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hex_loader.md
HEX_LOADER -- requirements
Module: hex_loader

Interface
REQ-001 SHALL have parameter BUS_ENDIANNESS, default "little"; "big" byte-swaps each data word before it drives wdata.
REQ-002 SHALL have parameter WORD_ADDR_SHIFT, default 2; bus byte address = record address << WORD_ADDR_SHIFT.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an ASCII byte is presented.
REQ-006 SHALL have port in_data, input, 8 bits: the ASCII character.
REQ-007 SHALL have port in_ready, output, 1 bit: the loader accepts in_data this cycle.
REQ-008 SHALL have port addr, output, 32 bits: generic-bus master address.
REQ-009 SHALL have port ren, output, 1 bit: generic-bus read enable; tied 0.
REQ-010 SHALL have port wen, output, 1 bit: generic-bus write enable.
REQ-011 SHALL have port wdata, output, 32 bits: generic-bus write data.
REQ-012 SHALL have port byte_en, output, 4 bits: generic-bus byte enables.
REQ-013 SHALL have port rdata, input, 32 bits: generic-bus read data; unused.
REQ-014 SHALL have port busy, input, 1 bit: generic-bus busy; a write completes on the first rising edge with wen=1 and busy=0.
REQ-015 SHALL have port done, output, 1 bit: EOF record accepted; sticky.
REQ-016 SHALL have port error, output, 2 bits: 0 none, 1 bad character, 2 checksum mismatch, 3 unsupported record; sticky.
REQ-017 SHALL have port rec_count, output, 16 bits: number of data records written; saturates at 16'hFFFF.

Function
REQ-018 SHALL decode Intel-HEX records of the form ':' LL AAAA TT D..D CC, with two ASCII hex digits per byte, most significant nibble first.
REQ-019 SHALL accept hex digits 0-9, a-f and A-F.
REQ-020 SHALL consume a byte only on a cycle where in_valid=1 and in_ready=1.
REQ-021 SHALL drive in_ready=1 in states IDLE, LEN, ADDR, TYPE, DATA and CSUM, and in_ready=0 in WRITE, DONE and ERR.
REQ-022 SHALL implement FSM states IDLE, LEN, ADDR, TYPE, DATA, CSUM, WRITE, DONE and ERR.
REQ-023 IDLE: ':' -> LEN; CR, LF and space are ignored; any other character -> ERR with error=1.
REQ-024 LEN -> ADDR after 2 digits; ADDR -> TYPE after 4 digits.
REQ-025 TYPE -> DATA if TT=00 and LL=04; TYPE -> CSUM if TT=01 and LL=00; any other TT/LL combination -> ERR with error=3, taken on the second TT digit.
REQ-026 DATA -> CSUM after 8 digits; the data word is assembled as D0 in bits [31:24] through D3 in bits [7:0].
REQ-027 CSUM, on the second digit, SHALL check that the 8-bit sum of all record bytes including CC equals 0 (modulo 256).
REQ-028 CSUM on a checksum pass: type 00 -> WRITE; type 01 -> DONE.
REQ-029 CSUM on a checksum fail -> ERR with error=2; no bus write occurs.
REQ-030 A non-hex character in LEN, ADDR, TYPE, DATA or CSUM SHALL move the FSM to ERR with error=1.
REQ-031 WRITE SHALL assert wen=1, addr={16'h0,AAAA}<<WORD_ADDR_SHIFT, byte_en=4'hF and wdata (swapped when BUS_ENDIANNESS is "big") from the cycle after the CSUM byte is consumed.
REQ-032 WRITE SHALL hold all bus outputs stable while busy=1.
REQ-033 On the completing edge (busy=0), WRITE SHALL increment rec_count and go to IDLE; wen=0 on the next cycle.
REQ-034 When not in WRITE, the loader SHALL drive wen=0, ren=0, addr=0, wdata=0 and byte_en=0.
REQ-035 DONE and ERR SHALL be terminal until RST; the done and error outputs are registered and valid from the cycle the FSM enters the state.
REQ-036 The loader SHALL NOT hold a pipelined second record; the next ':' is accepted no earlier than the cycle after the write completes.

Reset
REQ-037 RST=1 at a rising edge SHALL force IDLE and clear all counters and accumulators.
REQ-038 RST=1 at a rising edge SHALL force done=0, error=0, rec_count=0, in_ready=0, wen=0, ren=0, addr=0, wdata=0 and byte_en=0.
REQ-039 in_ready SHALL rise the cycle after RST deasserts.
REQ-040 RST asserted mid-record or mid-WRITE SHALL abandon the record with no further bus activity; a write already held by busy is dropped.

Verification
REQ-041 Stream ":0400400012345678A8\n" with busy=0 -> one cycle of wen=1, addr=0x100, wdata=0x12345678, byte_en=0xF; rec_count=1.
REQ-042 Same stream with BUS_ENDIANNESS="big" -> wdata=0x78563412.
REQ-043 Same stream with busy held 3 cycles -> wen high for exactly 4 cycles with stable outputs; in_ready=0 throughout; rec_count=1 after completion.
REQ-044 ":0400400012345678A9" -> error=2, wen never asserted, in_ready=0 afterward.
REQ-045 ":00000001FF" -> done=1 and error=0; ":02..." -> error=3; 'G' inside a DATA field -> error=1.
REQ-046 Lowercase record ":04004100deadbeefXX" (valid checksum) -> write to 0x104 with wdata=0xDEADBEEF.
REQ-047 RST pulsed after the 6th byte of a record -> no write, rec_count=0, and the next valid record loads correctly.
